// File: rtl/trig_play_ctrl_if.sv
// rtl/trig_play_ctrl_if.sv - request, configuration, RAM read port and status bundle for trig_play_ctrl
//
// Purpose: groups every non-clock/reset signal of the playback scheduler.
// Ports (master = scheduler side):
//   en, ccbped, fcyc, fcycm, load_act : start sources and lockouts (master input)
//   len, nrep, gap                    : pass length, extra passes, inter-pass gap (master input)
//   renb, raddr                       : pattern RAM port B enable/address (master output)
//   busy, pass_cnt, done, abort, ovr  : run status and event pulses (master output)
interface trig_play_ctrl_if #(
    parameter int AW = 13,
    parameter int CW = 8
) ();
    logic          en;
    logic          ccbped;
    logic          fcyc;
    logic          fcycm;
    logic          load_act;
    logic [AW-1:0] len;
    logic [CW-1:0] nrep;
    logic [CW-1:0] gap;

    logic          renb;
    logic [AW-1:0] raddr;
    logic          busy;
    logic [CW-1:0] pass_cnt;
    logic          done;
    logic          abort;
    logic          ovr;

    modport master (
        input  en, ccbped, fcyc, fcycm, load_act, len, nrep, gap,
        output renb, raddr, busy, pass_cnt, done, abort, ovr
    );

    modport slave (
        output en, ccbped, fcyc, fcycm, load_act, len, nrep, gap,
        input  renb, raddr, busy, pass_cnt, done, abort, ovr
    );
endinterface

// File: rtl/trig_play_ctrl.sv
// rtl/trig_play_ctrl.sv - trigger pattern playback scheduler driving the pattern RAM read port
//
// Purpose: turns start requests (pedestal pulse, FCYC rising edge, continuous FCYCM)
// into RAM read-enable/address sequences of LEN+1 words per pass, with NREP extra
// passes separated by GAP idle cycles. A JTAG pattern load kills any run.
// Ports:
//   clk   : system clock, also the RAM port B clock
//   rst_n : asynchronous active-low reset
//   bus   : trig_play_ctrl_if master modport (requests, config, RAM port, status)
// All outputs are registered.
module trig_play_ctrl #(
    parameter int AW = 13,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    trig_play_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    // Previous FCYC level; resets high so a level already present at reset
    // release is not mistaken for a rising edge.
    logic          fcyc_1;

    // Configuration captured at run start; mid-run changes are ignored.
    logic [AW-1:0] len_l;
    logic [CW-1:0] nrep_l;
    logic [CW-1:0] gap_l;
    logic [CW-1:0] gcnt;

    logic          renb_q;
    logic [AW-1:0] raddr_q;
    logic          busy_q;
    logic [CW-1:0] pass_q;
    logic          done_q;
    logic          abort_q;
    logic          ovr_q;

    logic          renb_nxt;
    logic [AW-1:0] raddr_nxt;
    logic          busy_nxt;
    logic [CW-1:0] pass_nxt;
    logic          done_nxt;
    logic          abort_nxt;
    logic          ovr_nxt;
    logic [CW-1:0] gcnt_nxt;
    logic          latch_cfg;

    logic          req;
    logic          end_pass;
    logic [CW-1:0] pass_inc;
    logic          cont;

    // Simultaneous sources collapse into one request.
    assign req = bus.en & ~bus.load_act &
                 (bus.ccbped | (bus.fcyc & ~fcyc_1) | bus.fcycm);

    assign end_pass = (state == S_PLAY) && (raddr_q == len_l);

    // Pass count saturates so a long FCYCM run never wraps back to zero.
    assign pass_inc = (pass_q == '1) ? pass_q : pass_q + 1'b1;

    // FCYCM is deliberately live (not latched): it extends the run while held.
    assign cont = ((pass_inc <= nrep_l) | bus.fcycm) & bus.en;

    // State register plus all registered outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fcyc_1   <= 1'b1;
            len_l    <= '0;
            nrep_l   <= '0;
            gap_l    <= '0;
            gcnt     <= '0;
            renb_q   <= 1'b0;
            raddr_q  <= '0;
            busy_q   <= 1'b0;
            pass_q   <= '0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            fcyc_1   <= bus.fcyc;
            if (latch_cfg) begin
                len_l  <= bus.len;
                nrep_l <= bus.nrep;
                gap_l  <= bus.gap;
            end
            gcnt     <= gcnt_nxt;
            renb_q   <= renb_nxt;
            raddr_q  <= raddr_nxt;
            busy_q   <= busy_nxt;
            pass_q   <= pass_nxt;
            done_q   <= done_nxt;
            abort_q  <= abort_nxt;
            ovr_q    <= ovr_nxt;
        end
    end

    // Next-state logic. A pattern load has priority over pass completion.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (bus.load_act) begin
                    state_nxt = S_IDLE;
                end else if (end_pass) begin
                    if (!cont) begin
                        state_nxt = S_IDLE;
                    end else if (gap_l != '0) begin
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_PLAY;
                    end
                end
            end
            S_GAP: begin
                if (bus.load_act) begin
                    state_nxt = S_IDLE;
                end else if (gcnt == CW'(1)) begin
                    // Leaving on count 1 yields exactly gap_l dead cycles.
                    state_nxt = S_PLAY;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        latch_cfg = 1'b0;
        gcnt_nxt  = gcnt;
        pass_nxt  = pass_q;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        ovr_nxt   = 1'b0;

        renb_nxt  = (state_nxt == S_PLAY);
        busy_nxt  = (state_nxt != S_IDLE);

        // Address only advances inside a pass; every pass start, gap entry
        // and exit to idle presents address zero.
        if ((state == S_PLAY) && (state_nxt == S_PLAY) && !end_pass) begin
            raddr_nxt = raddr_q + 1'b1;
        end else begin
            raddr_nxt = '0;
        end

        case (state)
            S_IDLE: begin
                if (req) begin
                    latch_cfg = 1'b1;
                    pass_nxt  = '0;
                end
            end
            S_PLAY: begin
                if (bus.load_act) begin
                    abort_nxt = 1'b1;
                end else if (end_pass) begin
                    pass_nxt = pass_inc;
                    if (!cont) begin
                        done_nxt = 1'b1;
                    end else if (gap_l != '0) begin
                        gcnt_nxt = gap_l;
                    end
                end
            end
            S_GAP: begin
                if (bus.load_act) begin
                    abort_nxt = 1'b1;
                end else begin
                    gcnt_nxt = gcnt - 1'b1;
                end
            end
            default: begin
                pass_nxt = pass_q;
            end
        endcase

        // Any request while a run is active (including its final edge) is lost.
        if ((state != S_IDLE) && req) begin
            ovr_nxt = 1'b1;
        end
    end

    assign bus.renb     = renb_q;
    assign bus.raddr    = raddr_q;
    assign bus.busy     = busy_q;
    assign bus.pass_cnt = pass_q;
    assign bus.done     = done_q;
    assign bus.abort    = abort_q;
    assign bus.ovr      = ovr_q;

endmodule
